// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter width helper.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-bit counter is still needed when only a single index exists.
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtract cell: computes a - b - bin, producing the
// difference bit and the borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & (b_i | bin_i)) | (b_i & bin_i);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one bit per cycle through a single
// full-subtract cell, LSB first, with a three-state IDLE/RUN/DONE controller.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  logic             cellDiff;
  logic             cellBorrow;
  logic [WIDTH-1:0] nextRes;

  full_subtractor u_cell (
    .a_i    (aSh_q[0]),
    .b_i    (bSh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cellDiff),
    .bout_o (cellBorrow)
  );

  // The newest difference bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
  assign nextRes = {cellDiff, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          aSh_d    = a;
          bSh_d    = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        busy     = 1'b1;
        aSh_d    = aSh_q >> 1;
        bSh_d    = bSh_q >> 1;
        borrow_d = cellBorrow;
        res_d    = nextRes;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          diff_d  = nextRes;
          bout_d  = cellBorrow;
          zero_d  = (nextRes == '0);
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      aSh_q    <= '0;
      bSh_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule
